// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared types and constants for the I/D cache arbiter
package cache_arbiter_pkg;
  localparam int LINE_BITS = 256;
  localparam int OFFSET_BITS = 5;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return {a[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones
module sat_counter32 #(
  parameter logic [31:0] INIT = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk)
    count <= rst ? INIT : (inc && count != '1) ? count + 32'd1 : count;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one physical memory port between I- and D-cache
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter logic [31:0] CNT_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [31:0]          i_addr,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_addr,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [31:0]          i_fill_count,
  output logic [31:0]          d_xfer_count
);
  arb_state_t state, state_n;
  grant_t last_grant, pick;
  logic [31:0] addr_q;
  logic wr_q, d_pend, busy;
  assign d_pend = d_read | d_write;
  assign pick = (i_read && (!d_pend || last_grant == GRANT_D)) ? GRANT_I : GRANT_D;
  // address and op are captured on grant so a client dropping its request cannot disturb the command
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      addr_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && (i_read || d_pend)) begin
        addr_q <= pick == GRANT_I ? i_addr : d_addr;
        wr_q   <= pick == GRANT_D && d_write;
      end
      if (i_resp) last_grant <= GRANT_I;
      else if (d_resp) last_grant <= GRANT_D;
    end
  always_comb begin
    state_n    = state == IDLE    ? ((i_read || d_pend) ? (pick == GRANT_I ? SERVE_I : SERVE_D) : IDLE) :
                 state == RELEASE ? IDLE :
                 pmem_resp        ? RELEASE : state;
    busy       = state == SERVE_I || state == SERVE_D;
    pmem_read  = state == SERVE_I || (state == SERVE_D && !wr_q);
    pmem_write = state == SERVE_D && wr_q;
    pmem_addr  = busy ? line_align(addr_q) : '0;
    pmem_wdata = state == SERVE_D ? d_wdata : '0;
    i_resp     = state == SERVE_I && pmem_resp;
    d_resp     = state == SERVE_D && pmem_resp;
    i_rdata    = i_resp ? pmem_rdata : '0;
    d_rdata    = d_resp ? pmem_rdata : '0;
  end
  sat_counter32 #(.INIT(CNT_INIT)) u_i_cnt (.clk(clk), .rst(rst), .inc(i_resp), .count(i_fill_count));
  sat_counter32 #(.INIT(CNT_INIT)) u_d_cnt (.clk(clk), .rst(rst), .inc(d_resp), .count(d_xfer_count));
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus randomized rounds against a transaction-level arbitration model
module tb_cache_arbiter;
  logic clk = 0, rst = 1;
  logic i_read = 0, d_read = 0, d_write = 0, pmem_resp = 0;
  logic [31:0] i_addr = 0, d_addr = 0;
  logic [255:0] d_wdata = 0, pmem_rdata = 0;
  logic [255:0] i_rdata, d_rdata, pmem_wdata, s_i_rdata, s_d_rdata, s_pmem_wdata;
  logic i_resp, d_resp, pmem_read, pmem_write, s_i_resp, s_d_resp, s_pmem_read, s_pmem_write;
  logic [31:0] pmem_addr, i_fill_count, d_xfer_count, s_pmem_addr, s_i_cnt, s_d_cnt;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .i_fill_count(i_fill_count), .d_xfer_count(d_xfer_count));

  cache_arbiter #(.CNT_INIT(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(s_d_rdata), .d_resp(s_d_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_addr(s_pmem_addr), .pmem_wdata(s_pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .i_fill_count(s_i_cnt), .d_xfer_count(s_d_cnt));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    cyc; cyc;
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; i_read = 1; d_write = 1; pmem_resp = 1;
    cyc; cyc; #2;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL reset_cmd got=%b exp=00", {pmem_read, pmem_write}); else passed++;
    checks++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL reset_resp got=%b exp=00", {i_resp, d_resp}); else passed++;
    checks++; if (pmem_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", pmem_addr); else passed++;
    checks++; if ({i_fill_count, d_xfer_count} !== 64'h0) $display("FAIL reset_counts got=%h/%h exp=0/0", i_fill_count, d_xfer_count); else passed++;
    checks++; if ({i_rdata, d_rdata} !== 512'h0) $display("FAIL reset_rdata got nonzero exp=0"); else passed++;
    i_read = 0; d_write = 0; pmem_resp = 0; rst = 0;
  endtask

  task automatic test_single_fill;
    do_reset;
    cyc; i_read = 1; i_addr = 32'h0000_1234; #2;
    checks++; if (pmem_read !== 1'b0) $display("FAIL fill_idle_cmd got=%b exp=0", pmem_read); else passed++;
    for (int k = 0; k < 3; k++) begin
      cyc; #2;
      checks++; if ({pmem_read, pmem_write, pmem_addr, i_resp} !== {2'b10, 32'h0000_1220, 1'b0})
        $display("FAIL fill_cmd cycle=%0d got=%b%b %h resp=%b exp=10 00001220 resp=0", k, pmem_read, pmem_write, pmem_addr, i_resp); else passed++;
    end
    cyc; pmem_resp = 1; pmem_rdata = {32{8'hA5}}; #2;
    checks++; if ({i_resp, d_resp} !== 2'b10) $display("FAIL fill_resp got=%b exp=10", {i_resp, d_resp}); else passed++;
    checks++; if (i_rdata !== {32{8'hA5}}) $display("FAIL fill_rdata got=%h exp=a5..", i_rdata); else passed++;
    cyc; pmem_resp = 0; i_read = 0; #2;
    checks++; if ({pmem_read, i_resp, i_rdata} !== 258'h0) $display("FAIL fill_release got cmd=%b resp=%b exp=0/0", pmem_read, i_resp); else passed++;
    checks++; if (i_fill_count !== 32'd1) $display("FAIL fill_count got=%0d exp=1", i_fill_count); else passed++;
  endtask

  task automatic test_tie;
    do_reset;
    for (int r = 0; r < 2; r++) begin
      cyc; i_read = 1; d_write = 1; i_addr = 32'h0000_4444 + r; d_addr = 32'h0000_9999; d_wdata = {8{32'hC0DE_0000 + r}}; #2;
      cyc; #2;
      checks++; if ({pmem_read, pmem_write, pmem_addr} !== {2'b10, 32'h0000_4440})
        $display("FAIL tie_first round=%0d got=%b%b %h exp=10 00004440", r, pmem_read, pmem_write, pmem_addr); else passed++;
      cyc; pmem_resp = 1; #2;
      checks++; if ({i_resp, d_resp} !== 2'b10) $display("FAIL tie_iresp round=%0d got=%b exp=10", r, {i_resp, d_resp}); else passed++;
      cyc; pmem_resp = 0; i_read = 0; #2;
      checks++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL tie_release round=%0d got=%b exp=00", r, {pmem_read, pmem_write}); else passed++;
      cyc; #2;
      checks++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL tie_idle round=%0d got=%b exp=00", r, {pmem_read, pmem_write}); else passed++;
      cyc; #2;
      checks++; if ({pmem_read, pmem_write, pmem_addr, pmem_wdata} !== {2'b01, 32'h0000_9980, {8{32'hC0DE_0000 + r}}})
        $display("FAIL tie_dwrite round=%0d got=%b%b %h exp=01 00009980", r, pmem_read, pmem_write, pmem_addr); else passed++;
      cyc; pmem_resp = 1; #2;
      checks++; if ({i_resp, d_resp} !== 2'b01) $display("FAIL tie_dresp round=%0d got=%b exp=01", r, {i_resp, d_resp}); else passed++;
      cyc; pmem_resp = 0; d_write = 0; #2;
    end
  endtask

  task automatic test_rw_both;
    do_reset;
    cyc; d_read = 1; d_write = 1; d_addr = 32'h8000_003F; #2;
    cyc; #2;
    checks++; if ({pmem_read, pmem_write, pmem_addr} !== {2'b01, 32'h8000_0020})
      $display("FAIL rw_both got=%b%b %h exp=01 80000020", pmem_read, pmem_write, pmem_addr); else passed++;
    cyc; pmem_resp = 1; #2;
    cyc; pmem_resp = 0; d_read = 0; d_write = 0; #2;
  endtask

  task automatic test_reset_mid;
    do_reset;
    cyc; d_write = 1; d_addr = 32'h0000_0100; #2;
    cyc; #2;
    checks++; if (pmem_write !== 1'b1) $display("FAIL rstmid_cmd got=%b exp=1", pmem_write); else passed++;
    cyc; rst = 1; #2;
    cyc; pmem_resp = 1; #2;
    checks++; if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) $display("FAIL rstmid_drop got=%b exp=0000", {pmem_read, pmem_write, i_resp, d_resp}); else passed++;
    checks++; if ({i_fill_count, d_xfer_count} !== 64'h0) $display("FAIL rstmid_counts got=%h/%h exp=0/0", i_fill_count, d_xfer_count); else passed++;
    cyc; rst = 0; pmem_resp = 0; d_write = 0; #2;
  endtask

  task automatic test_stray;
    do_reset;
    cyc; pmem_resp = 1; #2;
    checks++; if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) $display("FAIL stray_resp got=%b exp=0000", {i_resp, d_resp, pmem_read, pmem_write}); else passed++;
    cyc; pmem_resp = 0; i_read = 1; i_addr = 32'h0000_0040; #2;
    checks++; if (pmem_read !== 1'b0) $display("FAIL stray_state got=%b exp=0", pmem_read); else passed++;
    cyc; #2;
    checks++; if (pmem_read !== 1'b1) $display("FAIL stray_latency got=%b exp=1", pmem_read); else passed++;
    cyc; pmem_resp = 1; #2;
    cyc; pmem_resp = 0; i_read = 0; #2;
  endtask

  task automatic test_saturation;
    logic [32:0] sum;
    logic [31:0] exp_sat;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      cyc; d_read = 1; d_addr = 32'h0000_2000; #2;
      cyc; pmem_resp = 1; pmem_rdata = {8{32'h1234_5678}}; #2;
      checks++; if ({s_d_resp, s_d_rdata} !== {1'b1, {8{32'h1234_5678}}}) $display("FAIL sat_resp k=%0d got=%b exp=1", k, s_d_resp); else passed++;
      cyc; pmem_resp = 0; d_read = 0; #2;
      sum = 33'h0_FFFF_FFFE + 33'(k + 1);
      exp_sat = sum > 33'h0_FFFF_FFFF ? 32'hFFFF_FFFF : sum[31:0];
      checks++; if (s_d_cnt !== exp_sat) $display("FAIL sat_count k=%0d got=%h exp=%h", k, s_d_cnt, exp_sat); else passed++;
      checks++; if (d_xfer_count !== 32'(k + 1)) $display("FAIL sat_plain_count k=%0d got=%0d exp=%0d", k, d_xfer_count, k + 1); else passed++;
    end
  endtask

  task automatic test_random;
    int mi, md, n, lat, nsrv;
    int ord[2];
    bit last_i, wi, wd, dw, er, ew;
    logic [31:0] ia, da, ea;
    logic [255:0] wdat, rd;
    do_reset;
    mi = 0; md = 0; last_i = 0;
    for (int r = 0; r < 60; r++) begin
      wi = 1'($urandom_range(0, 1)); wd = 1'($urandom_range(0, 1));
      if (!wi && !wd) wd = 1;
      dw = 1'($urandom_range(0, 1)); ia = $urandom; da = $urandom; wdat = {8{$urandom}};
      nsrv = int'(wi) + int'(wd);
      ord[0] = (wi && (!wd || !last_i)) ? 0 : 1;
      ord[1] = 1 - ord[0];
      cyc; i_read = wi; i_addr = ia; d_write = wd && dw; d_read = wd && (!dw || $urandom_range(0, 1) == 1);
      d_addr = da; d_wdata = wdat; #2;
      n = 0;
      for (int k = 0; k < nsrv; k++) begin
        while (!(pmem_read || pmem_write) && n < 6) begin cyc; #2; n++; end
        checks++; if (n != (k == 0 ? 1 : 3)) $display("FAIL rnd_latency r=%0d k=%0d got=%0d exp=%0d", r, k, n, k == 0 ? 1 : 3); else passed++;
        ea = ord[k] == 0 ? {ia[31:5], 5'b0} : {da[31:5], 5'b0};
        er = ord[k] == 0 || !dw;
        ew = ord[k] == 1 && dw;
        checks++; if ({pmem_read, pmem_write, pmem_addr} !== {er, ew, ea})
          $display("FAIL rnd_cmd r=%0d k=%0d got=%b%b %h exp=%b%b %h", r, k, pmem_read, pmem_write, pmem_addr, er, ew, ea); else passed++;
        if (ew) begin
          checks++; if (pmem_wdata !== wdat) $display("FAIL rnd_wdata r=%0d got=%h exp=%h", r, pmem_wdata, wdat); else passed++;
        end
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          cyc; #2;
          checks++; if ({pmem_read, pmem_write, pmem_addr, i_resp, d_resp} !== {er, ew, ea, 2'b00})
            $display("FAIL rnd_hold r=%0d got=%b%b %h resp=%b%b", r, pmem_read, pmem_write, pmem_addr, i_resp, d_resp); else passed++;
        end
        rd = {8{$urandom}};
        cyc; pmem_resp = 1; pmem_rdata = rd; #2;
        checks++; if ({i_resp, d_resp} !== (ord[k] == 0 ? 2'b10 : 2'b01))
          $display("FAIL rnd_resp r=%0d k=%0d got=%b%b exp_client=%0d", r, k, i_resp, d_resp, ord[k]); else passed++;
        checks++; if ({i_rdata, d_rdata} !== (ord[k] == 0 ? {rd, 256'h0} : {256'h0, rd}))
          $display("FAIL rnd_rdata r=%0d k=%0d got_i=%h got_d=%h exp=%h", r, k, i_rdata, d_rdata, rd); else passed++;
        if (ord[k] == 0) mi++; else md++;
        last_i = ord[k] == 0;
        cyc; pmem_resp = 0; pmem_rdata = {8{$urandom}};
        if (ord[k] == 0) i_read = 0; else begin d_read = 0; d_write = 0; end
        #2; n = 1;
        checks++; if ({i_fill_count, d_xfer_count, i_resp, d_resp} !== {32'(mi), 32'(md), 2'b00})
          $display("FAIL rnd_counts r=%0d got=%0d/%0d exp=%0d/%0d", r, i_fill_count, d_xfer_count, mi, md); else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_fill;
    test_tie;
    test_rw_both;
    test_reset_mid;
    test_stray;
    test_saturation;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
